// File: rtl/downcounter9bit_timer.sv
// -----------------------------------------------------------------------------
// downcounter9bit_timer
//
// Loadable 9-bit down-counter/timer with one-shot and auto-reload (periodic)
// modes. A start value is loaded, the count decrements on enabled clocks, and
// a one-clock terminal-count pulse (tc) is raised on the edge where the count
// leaves 1. In periodic mode the count is refilled from the reload register
// on that edge. In one-shot mode it parks at 0 with a sticky done flag.
//
// Ports:
//   clk         counter clock, all state updates on the rising edge
//   clr         asynchronous active-high reset
//   enable      count enable, decrement only while high
//   load        synchronous load strobe, samples load_val
//   load_val    [8:0] start/reload value (0..511)
//   auto_reload 1 = periodic, 0 = one-shot; sampled at each terminal count
//   count       [8:0] current count value
//   tc          registered terminal-count pulse
//   busy        high while running
//   done        sticky one-shot completion flag
// -----------------------------------------------------------------------------
module downcounter9bit_timer #(
  parameter int RISE_DLY = 10,  // simulation-only 0->1 output delay (ns)
  parameter int FALL_DLY = 10   // simulation-only 1->0 output delay (ns)
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       enable,
  input  logic       load,
  input  logic [8:0] load_val,
  input  logic       auto_reload,
  output logic [8:0] count,
  output logic       tc,
  output logic       busy,
  output logic       done
);

  // Output edge delays are applied by the simulation model wrapper around this
  // block. Here they only have to be non-negative to be meaningful.
  if (RISE_DLY < 0 || FALL_DLY < 0) begin : g_negative_delay_unsupported
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] count_q, count_d;
  logic [8:0] reload_q, reload_d;
  logic       tc_q, tc_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      count_q  <= 9'd0;
      reload_q <= 9'd0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default at the top of the block, so no path can
  // leave it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;   // tc is a pulse: it drops unless re-raised this edge

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // Both resting states accept a load the same way; enable is ignored.
        if (load) begin
          count_d  = load_val;
          reload_d = load_val;
          state_d  = (load_val != 9'd0) ? S_RUN : S_IDLE;
        end
      end

      S_RUN: begin
        if (load) begin
          // Load beats decrement; a zero load stops the timer quietly.
          count_d  = load_val;
          reload_d = load_val;
          state_d  = (load_val != 9'd0) ? S_RUN : S_IDLE;
        end else if (enable) begin
          if (count_q > 9'd1) begin
            count_d = count_q - 9'd1;
          end else if (count_q == 9'd1) begin
            // Terminal count: the 1->0 step. Periodic mode refills instead of
            // landing on 0, so reload value 1 gives tc on every enabled edge.
            tc_d = 1'b1;
            if (auto_reload) begin
              count_d = reload_q;
            end else begin
              count_d = 9'd0;
              state_d = S_DONE;
            end
          end
          // count_q == 0 cannot occur in RUN (a zero load goes to IDLE); it
          // holds rather than wrapping to 511.
        end
      end

      default: begin
        state_d = S_IDLE;
        count_d = 9'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    count = count_q;
    tc    = tc_q;
    busy  = (state_q == S_RUN);
    done  = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_downcounter9bit_timer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// Self-checking bench for downcounter9bit_timer: a table of directed vectors,
// hand-written clr/max-value sequences, then randomized stimulus compared with
// a behavioural timer model.
// -----------------------------------------------------------------------------
module tb_downcounter9bit_timer;

  logic       clk;
  logic       clr;
  logic       enable;
  logic       load;
  logic [8:0] load_val;
  logic       auto_reload;
  logic [8:0] count;
  logic       tc;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  downcounter9bit_timer #(
    .RISE_DLY(10),
    .FALL_DLY(10)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .enable     (enable),
    .load       (load),
    .load_val   (load_val),
    .auto_reload(auto_reload),
    .count      (count),
    .tc         (tc),
    .busy       (busy),
    .done       (done)
  );

  // 100 ns clock; rising edges at 100, 200, ...
  initial begin
    clk = 1'b1;
    forever #50 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Behavioural model: remaining count, stored period, running/finished flags.
  // ---------------------------------------------------------------------------
  int m_count;
  int m_reload;
  bit m_running;
  bit m_finished;
  bit m_tc;

  task automatic model_reset();
    m_count    = 0;
    m_reload   = 0;
    m_running  = 0;
    m_finished = 0;
    m_tc       = 0;
  endtask

  task automatic model_edge(input bit ld, input int lv, input bit en, input bit ar);
    m_tc = 0;
    if (ld) begin
      m_reload   = lv;
      m_count    = lv;
      m_running  = (lv != 0);
      m_finished = 0;
    end else if (m_running && en) begin
      if (m_count == 1) begin
        m_tc = 1;
        if (ar) m_count = m_reload;
        else begin
          m_count    = 0;
          m_running  = 0;
          m_finished = 1;
        end
      end else begin
        m_count = m_count - 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_out(input string tag);
    check({tag, " count"}, 32'(count), 32'(m_count));
    check({tag, " tc"},    32'(tc),    32'(m_tc));
    check({tag, " busy"},  32'(busy),  32'(m_running));
    check({tag, " done"},  32'(done),  32'(m_finished));
  endtask

  // Drive inputs, advance one edge in DUT and model, compare 1 ns later.
  task automatic apply(input bit ld, input logic [8:0] lv, input bit en, input bit ar,
                       input string tag);
    load        = ld;
    load_val    = lv;
    enable      = en;
    auto_reload = ar;
    model_edge(ld, int'(lv), en, ar);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         ld;
    logic [8:0] lv;
    bit         en;
    bit         ar;
    logic [8:0] exp_count;
    bit         exp_tc;
    bit         exp_busy;
    bit         exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit ld, input int lv, input bit en, input bit ar,
                     input int c, input bit t, input bit b, input bit d);
    vec_t v;
    v.ld = ld; v.lv = 9'(lv); v.en = en; v.ar = ar;
    v.exp_count = 9'(c); v.exp_tc = t; v.exp_busy = b; v.exp_done = d;
    vecs.push_back(v);
  endtask

  initial begin
    int n_edges;
    bit seen_tc;

    model_reset();

    // --- one-shot: 3,2,1,0 then 5 idle cycles in DONE
    add(1, 3, 1, 0,   3, 0, 1, 0);
    add(0, 0, 1, 0,   2, 0, 1, 0);
    add(0, 0, 1, 0,   1, 0, 1, 0);
    add(0, 0, 1, 0,   0, 1, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0, 0, 0, 1);
    // --- pause: 10,9,8,7,6, hold 6 twice, resume 5; then down to 2
    add(1, 10, 1, 0, 10, 0, 1, 0);
    for (int c = 9; c >= 6; c--) add(0, 0, 1, 0, c, 0, 1, 0);
    add(0, 0, 0, 0,   6, 0, 1, 0);
    add(0, 0, 0, 0,   6, 0, 1, 0);
    for (int c = 5; c >= 2; c--) add(0, 0, 1, 0, c, 0, 1, 0);
    // --- load priority at count 2, then zero load to IDLE
    add(1, 7, 1, 0,   7, 0, 1, 0);
    add(1, 0, 1, 0,   0, 0, 0, 0);
    add(0, 0, 1, 0,   0, 0, 0, 0);
    add(1, 0, 1, 0,   0, 0, 0, 0);
    // --- auto-reload period 4 over 12 edges: 3 tc pulses
    add(1, 4, 1, 1,   4, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      add(0, 0, 1, 1, 3, 0, 1, 0);
      add(0, 0, 1, 1, 2, 0, 1, 0);
      add(0, 0, 1, 1, 1, 0, 1, 0);
      add(0, 0, 1, 1, 4, 1, 1, 0);
    end
    // --- period 1: tc every cycle; then one-shot finish; zero load from DONE
    add(1, 1, 1, 1,   1, 0, 1, 0);
    add(0, 0, 1, 1,   1, 1, 1, 0);
    add(0, 0, 1, 1,   1, 1, 1, 0);
    add(0, 0, 1, 0,   0, 1, 0, 1);
    add(0, 0, 1, 0,   0, 0, 0, 1);
    add(1, 0, 1, 0,   0, 0, 0, 0);

    // --- reset window: clr with load/enable active
    clr = 1'b0; enable = 1'b1; load = 1'b1; load_val = 9'd5; auto_reload = 1'b0;
    #10 clr = 1'b1;
    #5  check_out("reset early");
    #30 check_out("reset late");
    #5  clr = 1'b0;
    load = 1'b0;

    // --- table
    foreach (vecs[i]) begin
      load = vecs[i].ld; load_val = vecs[i].lv;
      enable = vecs[i].en; auto_reload = vecs[i].ar;
      model_edge(vecs[i].ld, int'(vecs[i].lv), vecs[i].en, vecs[i].ar);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d tc",    i), 32'(tc),    32'(vecs[i].exp_tc));
      check($sformatf("vec%0d busy",  i), 32'(busy),  32'(vecs[i].exp_busy));
      check($sformatf("vec%0d done",  i), 32'(done),  32'(vecs[i].exp_done));
    end

    // --- max value, 100 edges, then clr across a rising edge
    apply(1, 9'd511, 1, 0, "max load");
    for (int i = 0; i < 100; i++) apply(0, 9'd0, 1, 0, "max run");
    check("max after 100 edges", 32'(count), 32'd411);
    @(negedge clk);
    clr = 1'b1; load = 1'b1; load_val = 9'd5; enable = 1'b1;
    #1 model_reset();
    check_out("mid clr immediate");
    @(posedge clk);
    #5 check_out("mid clr over edge");
    #4 clr = 1'b0;
    load = 1'b0;

    // --- full 511 run: tc exactly on the 511th enabled edge
    apply(1, 9'd511, 1, 0, "full load");
    n_edges = 0;
    seen_tc = 0;
    for (int i = 0; i < 600 && !seen_tc; i++) begin
      apply(0, 9'd0, 1, 0, "full run");
      n_edges++;
      if (tc === 1'b1) seen_tc = 1;
    end
    check("full 511 edges to tc", 32'(n_edges), 32'd511);
    check("full 511 done", 32'(done), 32'd1);

    // --- clr clears a tc pulse in flight
    apply(1, 9'd2, 1, 1, "inflight load");
    apply(0, 9'd0, 1, 1, "inflight run");
    apply(0, 9'd0, 1, 1, "inflight tc");
    #10 clr = 1'b1;
    #1 model_reset();
    check_out("inflight clr");
    #10 clr = 1'b0;

    // --- randomized against the model
    for (int i = 0; i < 2000; i++) begin
      bit         r_ld;
      logic [8:0] r_lv;
      r_ld = ($urandom_range(0, 15) == 0);
      r_lv = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511))
                                         : 9'($urandom_range(0, 6));
      apply(r_ld, r_lv, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 149) == 0) begin
        clr = 1'b1;
        #2 model_reset();
        check_out("rand clr");
        #10 clr = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/downcounter9bit_timer.md
Name: downcounter9bit_timer

Overview:
- Loadable 9-bit down-counter/timer; the count-down counterpart to the team's 9-bit up-counter.
- Software/bench loads a start value, the block decrements on enabled clocks, and it flags terminal count.
- Supports one-shot and auto-reload (periodic) modes.
- Driven by the shared clk generator module; used for timeouts and periodic ticks.

Parameters:
RISE_DLY, 10, simulation-only delay (ns) applied to 0->1 transitions of count bits, tc, busy, done; no synthesis effect
FALL_DLY, 10, simulation-only delay (ns) applied to 1->0 transitions of the same outputs; no synthesis effect

Ports:
clk  input  1  counter clock; all state updates on rising edge
clr  input  1  reset, asynchronous, active-high
enable  input  1  count enable; decrement permitted only when high
load  input  1  synchronous load strobe; samples load_val
load_val  input  9  start/reload value, unsigned 0..511
auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled at every terminal-count edge
count  output  9  current count value
tc  output  1  terminal-count pulse, exactly one clock wide
busy  output  1  high while in RUN state
done  output  1  sticky one-shot completion flag

Behaviour:
- Reset (clr=1, asynchronous, immediate):
  - count=0, tc=0, busy=0, done=0
  - reload register=0, state=IDLE
  - clr held high overrides all inputs; release takes effect at the next rising edge.
- Internal reload register (9 bits) is written on every accepted load.
- FSM states: IDLE, RUN, DONE. busy=1 only in RUN; done=1 only in DONE.
- IDLE:
  - load with load_val!=0: count<=load_val, go to RUN.
  - load with load_val==0: count<=0, stay IDLE, no tc.
  - No load: everything holds.
- RUN, evaluated in priority order each edge:
  - 1) load: count<=load_val, reload reg<=load_val, tc<=0; load_val==0 sends the FSM to IDLE. Load beats decrement even when enable=1.
  - 2) enable=1 and count>1: count<=count-1, tc<=0.
  - 3) enable=1 and count==1, auto_reload=1: count<=reload reg, tc<=1, stay RUN.
  - 4) enable=1 and count==1, auto_reload=0: count<=0, tc<=1, go to DONE.
  - 5) enable=0: hold count and state (pause), tc<=0.
- DONE:
  - count=0 and done=1 until load or clr.
  - load with load_val!=0 goes to RUN (done<=0).
  - load with load_val==0 goes to IDLE (done<=0).
  - enable is ignored.
- tc is registered:
  - Asserted on the same edge count leaves 1; deasserted the next edge.
  - Never high for two consecutive cycles, except in periodic mode with reload value 1 and enable held high (then high every cycle).
- Terminal count is the 1->0 transition only. No wrap-around: count never goes below 0 and never goes from 0 to 511.
- Period in auto-reload mode is N enabled clocks for reload value N (N=1..511).
- Width: 9-bit unsigned. load_val=511 gives 511 enabled clocks to tc.
- clr asserted mid-RUN aborts immediately with no tc; a tc pulse in flight is cleared.
- Latency:
  - load to count update: 1 edge.
  - Last enabled edge to tc: same edge.
- Outputs carry RISE_DLY/FALL_DLY only in simulation; logic is otherwise fully synchronous except clr.

Test Plan:
- Reset: clr=1 at t=10ns for 40ns with enable=1, load=1, load_val=9'd5 -> count=0, tc=0, busy=0, done=0 throughout the clr window; no edge during clr changes state.
- One-shot: load 9'd3, auto_reload=0, enable=1 (100ns clock) -> count 3,2,1,0 on successive edges; tc high exactly one cycle on the 1->0 edge; busy falls and done rises on that edge; count stays 0 for 5 further cycles.
- Pause: load 9'd10, enable high for 4 edges then low for 2 edges then high -> count 10,9,8,7,6 holds at 6 for 2 edges, then resumes 5; no tc during pause.
- Auto-reload: load 9'd4, auto_reload=1, enable=1 for 12 edges -> tc every 4th edge (3 pulses); count sequence 4,3,2,1,4,3,...; busy stays 1; done stays 0.
- Load priority/zero: in RUN at count=2, assert load with 9'd7 and enable=1 -> count=7 next edge, no tc. Then load 9'd0 -> count=0, state IDLE, busy=0, tc=0.
- Mid-run clr and max value: load 9'd511, run 100 edges (count=411), assert clr for 60ns -> count=0 immediately and no tc. Reload 511 and run to completion -> tc after exactly 511 enabled edges.
